// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, drives the instruction SRAM-like bus and
// hands {adel, pc, inst} to if_stage, applying branch and exception redirects.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC         = 32'hbfc00000,
    parameter int          BR_BUS_WD        = 65,
    parameter int          PFS_TO_FS_BUS_WD = 65
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        fs_allowin,
    input  logic [BR_BUS_WD-1:0]        br_bus,
    input  logic                        handle_ex,
    input  logic [31:0]                 ex_pc,
    output logic                        pfs_to_fs_valid,
    output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
    output logic                        inst_sram_req,
    output logic                        inst_sram_wr,
    output logic [1:0]                  inst_sram_size,
    output logic [31:0]                 inst_sram_addr,
    output logic [31:0]                 inst_sram_wdata,
    input  logic                        inst_sram_addr_ok,
    input  logic                        inst_sram_data_ok,
    input  logic [31:0]                 inst_sram_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]                  state, state_nx;
    logic [31:0]                 fetch_pc, fetch_nx;
    logic [31:0]                 issued_pc, issued_nx;
    logic                        out_valid, valid_nx;
    logic [PFS_TO_FS_BUS_WD-1:0] out_bus, bus_nx;
    logic                        discard, discard_nx;
    logic                        br_pend, pend_nx;
    logic [31:0]                 br_tgt, br_slot;
    logic                        redir_v, redir_v_nx;
    logic [31:0]                 redir_pc, redir_pc_nx;

    logic        br_taken;
    logic [31:0] br_target, br_pc;
    logic        eff_pend, consume, unaligned;
    logic [31:0] eff_tgt, eff_slot, wrong_pc;

    assign br_taken  = br_bus[64];
    assign br_target = br_bus[63:32];
    assign br_pc     = br_bus[31:0];

    // A branch notice takes effect in the cycle it arrives as well as later.
    assign eff_pend  = br_pend | br_taken;
    assign eff_tgt   = br_taken ? br_target : br_tgt;
    assign eff_slot  = br_taken ? (br_pc + 32'd4) : br_slot;
    assign wrong_pc  = eff_slot + 32'd4;
    assign unaligned = (fetch_pc[1:0] != 2'b00);

    // An exception hitting a request still waiting for addr_ok is parked in
    // redir_* so the bus address stays stable until the handshake completes.
    always_comb begin
        state_nx    = state;
        fetch_nx    = fetch_pc;
        issued_nx   = issued_pc;
        valid_nx    = out_valid;
        bus_nx      = out_bus;
        discard_nx  = discard;
        redir_v_nx  = redir_v;
        redir_pc_nx = redir_pc;
        consume     = 1'b0;
        if (handle_ex) begin
            valid_nx = 1'b0;
            case (state)
                S_REQ: begin
                    if (unaligned) begin
                        fetch_nx = ex_pc;
                    end else begin
                        discard_nx = 1'b1;
                        if (inst_sram_addr_ok) begin
                            state_nx   = S_WAIT;
                            issued_nx  = fetch_pc;
                            fetch_nx   = ex_pc;
                            redir_v_nx = 1'b0;
                        end else begin
                            redir_v_nx  = 1'b1;
                            redir_pc_nx = ex_pc;
                        end
                    end
                end
                S_WAIT: begin
                    fetch_nx = ex_pc;
                    if (inst_sram_data_ok) begin
                        discard_nx = 1'b0;
                        state_nx   = S_REQ;
                    end else begin
                        discard_nx = 1'b1;
                    end
                end
                default: begin
                    fetch_nx = ex_pc;
                    state_nx = S_REQ;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_REQ;
                    if (eff_pend && fetch_pc == wrong_pc) begin
                        fetch_nx = eff_tgt;
                        consume  = 1'b1;
                    end
                end
                S_REQ: begin
                    if (unaligned) begin
                        state_nx = S_HOLD;
                        valid_nx = 1'b1;
                        bus_nx   = {1'b1, fetch_pc, 32'h0};
                    end else if (inst_sram_addr_ok) begin
                        state_nx  = S_WAIT;
                        issued_nx = fetch_pc;
                        if (redir_v) begin
                            fetch_nx   = redir_pc;
                            redir_v_nx = 1'b0;
                        end else if (eff_pend && fetch_pc == wrong_pc) begin
                            discard_nx = 1'b1;
                            fetch_nx   = eff_tgt;
                            consume    = 1'b1;
                        end else if (eff_pend && fetch_pc == eff_slot) begin
                            fetch_nx = eff_tgt;
                            consume  = 1'b1;
                        end else begin
                            fetch_nx = fetch_pc + 32'd4;
                        end
                    end
                end
                S_WAIT: begin
                    if (eff_pend && issued_pc == wrong_pc) begin
                        fetch_nx = eff_tgt;
                        consume  = 1'b1;
                        if (inst_sram_data_ok) begin
                            discard_nx = 1'b0;
                            state_nx   = S_REQ;
                        end else begin
                            discard_nx = 1'b1;
                        end
                    end else begin
                        if (eff_pend && fetch_pc == wrong_pc) begin
                            fetch_nx = eff_tgt;
                            consume  = 1'b1;
                        end
                        if (inst_sram_data_ok) begin
                            if (discard) begin
                                discard_nx = 1'b0;
                                state_nx   = S_REQ;
                            end else begin
                                valid_nx = 1'b1;
                                bus_nx   = {1'b0, issued_pc, inst_sram_rdata};
                                state_nx = S_HOLD;
                            end
                        end
                    end
                end
                default: begin
                    if (eff_pend && !out_bus[64] && out_bus[63:32] == wrong_pc) begin
                        valid_nx = 1'b0;
                        fetch_nx = eff_tgt;
                        consume  = 1'b1;
                        state_nx = S_REQ;
                    end else begin
                        if (eff_pend && fetch_pc == wrong_pc) begin
                            fetch_nx = eff_tgt;
                            consume  = 1'b1;
                        end
                        if (fs_allowin) begin
                            valid_nx = 1'b0;
                            state_nx = S_REQ;
                        end
                    end
                end
            endcase
        end
        if (handle_ex || consume) pend_nx = 1'b0;
        else if (br_taken)        pend_nx = 1'b1;
        else                      pend_nx = br_pend;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            out_valid <= 1'b0;
            out_bus   <= '0;
            discard   <= 1'b0;
            br_pend   <= 1'b0;
            br_tgt    <= '0;
            br_slot   <= '0;
            redir_v   <= 1'b0;
            redir_pc  <= '0;
        end else begin
            state     <= state_nx;
            fetch_pc  <= fetch_nx;
            issued_pc <= issued_nx;
            out_valid <= valid_nx;
            out_bus   <= bus_nx;
            discard   <= discard_nx;
            br_pend   <= pend_nx;
            redir_v   <= redir_v_nx;
            redir_pc  <= redir_pc_nx;
            if (br_taken) begin
                br_tgt  <= br_target;
                br_slot <= br_pc + 32'd4;
            end
        end
    end

    assign pfs_to_fs_valid = out_valid;
    assign pfs_to_fs_bus   = out_bus;
    assign inst_sram_req   = (state == S_REQ) && !unaligned;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = '0;

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: a one-cycle-latency instruction memory plus
// cycle-by-cycle vectors of inputs and expected bus/handshake outputs.
module tb_pre_if_stage;

    localparam logic [31:0] PC0 = 32'hbfc00000;
    localparam logic [31:0] TGT = 32'hbfc00100;

    typedef struct {
        logic        allow;
        logic        ready;
        logic        hold;
        logic        brt;
        logic [31:0] brtgt;
        logic [31:0] brpc;
        logic        ex;
        logic [31:0] expc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [64:0] ebus;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h00ff_ff00;
    endfunction

    function automatic logic [64:0] okb(input logic [31:0] pc);
        return {1'b0, pc, mem_word(pc)};
    endfunction

    function automatic vec_t cy(input logic allow, input logic ready, input logic ereq,
                                input logic [31:0] eaddr, input logic evalid,
                                input logic [64:0] ebus);
        vec_t v;
        v.allow = allow; v.ready = ready; v.hold = 1'b0;
        v.brt = 1'b0; v.brtgt = '0; v.brpc = '0;
        v.ex = 1'b0; v.expc = '0;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.ebus = ebus;
        return v;
    endfunction

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fs_allowin = 1'b0;
    logic [64:0] br_bus = '0;
    logic        handle_ex = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        pfs_to_fs_valid;
    logic [64:0] pfs_to_fs_bus;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic        mem_ready = 1'b0;
    logic        data_hold = 1'b0;
    logic        pend;
    logic [31:0] paddr;
    int          checks = 0;
    int          failures = 0;
    vec_t        tbl[16];

    always #5 clk = ~clk;

    pre_if_stage #(.RESET_PC(32'hbfc00000), .BR_BUS_WD(65), .PFS_TO_FS_BUS_WD(65)) dut (
        .clk(clk), .resetn(resetn), .fs_allowin(fs_allowin), .br_bus(br_bus),
        .handle_ex(handle_ex), .ex_pc(ex_pc),
        .pfs_to_fs_valid(pfs_to_fs_valid), .pfs_to_fs_bus(pfs_to_fs_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata)
    );

    assign inst_sram_addr_ok = inst_sram_req & mem_ready;
    assign inst_sram_data_ok = pend & ~data_hold;
    assign inst_sram_rdata   = inst_sram_data_ok ? mem_word(paddr) : 32'h0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend  <= 1'b0;
            paddr <= '0;
        end else if (inst_sram_addr_ok) begin
            pend  <= 1'b1;
            paddr <= inst_sram_addr;
        end else if (inst_sram_data_ok) begin
            pend  <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input vec_t v);
        fs_allowin = v.allow;
        mem_ready  = v.ready;
        data_hold  = v.hold;
        br_bus     = {v.brt, v.brtgt, v.brpc};
        handle_ex  = v.ex;
        ex_pc      = v.expc;
        chk({nm, ".req"}, {64'h0, inst_sram_req}, {64'h0, v.ereq});
        if (v.ereq) chk({nm, ".addr"}, {33'h0, inst_sram_addr}, {33'h0, v.eaddr});
        chk({nm, ".valid"}, {64'h0, pfs_to_fs_valid}, {64'h0, v.evalid});
        if (v.evalid) chk({nm, ".bus"}, pfs_to_fs_bus, v.ebus);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; fs_allowin = 1'b0; mem_ready = 1'b0; data_hold = 1'b0;
        br_bus = '0; handle_ex = 1'b0; ex_pc = '0;
        @(negedge clk);
        chk("rst.req", {64'h0, inst_sram_req}, 65'h0);
        chk("rst.valid", {64'h0, pfs_to_fs_valid}, 65'h0);
        chk("rst.bus", pfs_to_fs_bus, 65'h0);
        chk("rst.const", {inst_sram_wr, inst_sram_size, inst_sram_wdata}, {30'h0, 1'b0, 2'b10, 32'h0});
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        vec_t t;
        tbl[0]  = cy(1, 1, 0, '0,        0, '0);
        tbl[1]  = cy(1, 1, 1, PC0,       0, '0);
        tbl[2]  = cy(1, 1, 0, '0,        0, '0);
        tbl[3]  = cy(1, 1, 0, '0,        1, okb(PC0));
        tbl[4]  = cy(1, 1, 1, PC0 + 4,   0, '0);
        tbl[5]  = cy(1, 1, 0, '0,        0, '0);
        tbl[6]  = cy(0, 1, 0, '0,        1, okb(PC0 + 4));
        tbl[7]  = cy(0, 1, 0, '0,        1, okb(PC0 + 4));
        tbl[8]  = cy(0, 1, 0, '0,        1, okb(PC0 + 4));
        tbl[9]  = cy(0, 1, 0, '0,        1, okb(PC0 + 4));
        tbl[10] = cy(0, 1, 0, '0,        1, okb(PC0 + 4));
        tbl[11] = cy(1, 1, 0, '0,        1, okb(PC0 + 4));
        tbl[12] = cy(1, 1, 1, PC0 + 8,   0, '0);
        tbl[13] = cy(1, 1, 0, '0,        0, '0);
        tbl[14] = cy(1, 1, 0, '0,        1, okb(PC0 + 8));
        tbl[15] = cy(1, 1, 1, PC0 + 12,  0, '0);

        do_reset();
        for (int i = 0; i < 16; i++) step($sformatf("seq%0d", i), tbl[i]);

        // branch arrives while the delay slot is in WAIT
        do_reset();
        for (int i = 0; i < 5; i++) step($sformatf("br_b%0d", i), tbl[i]);
        t = cy(1, 1, 0, '0, 0, '0); t.brt = 1; t.brtgt = TGT; t.brpc = PC0;
        step("br_b5", t);
        step("br_b6", cy(1, 1, 0, '0, 1, okb(PC0 + 4)));
        step("br_b7", cy(1, 1, 1, TGT, 0, '0));
        step("br_b8", cy(1, 1, 0, '0, 0, '0));
        step("br_b9", cy(1, 1, 0, '0, 1, okb(TGT)));

        // branch arrives while the wrong-path request is held without addr_ok
        do_reset();
        for (int i = 0; i < 6; i++) step($sformatf("br_c%0d", i), tbl[i]);
        step("br_c6", cy(1, 1, 0, '0, 1, okb(PC0 + 4)));
        t = cy(1, 0, 1, PC0 + 8, 0, '0); t.brt = 1; t.brtgt = TGT; t.brpc = PC0;
        step("br_c7", t);
        step("br_c8", cy(1, 0, 1, PC0 + 8, 0, '0));
        step("br_c9", cy(1, 0, 1, PC0 + 8, 0, '0));
        step("br_c10", cy(1, 1, 1, PC0 + 8, 0, '0));
        step("br_c11", cy(1, 1, 0, '0, 0, '0));
        step("br_c12", cy(1, 1, 1, TGT, 0, '0));
        step("br_c13", cy(1, 1, 0, '0, 0, '0));
        step("br_c14", cy(1, 1, 0, '0, 1, okb(TGT)));

        // exception during WAIT, then exception coinciding with data_ok
        do_reset();
        for (int i = 0; i < 2; i++) step($sformatf("ex_d%0d", i), tbl[i]);
        t = cy(1, 1, 0, '0, 0, '0); t.hold = 1; t.ex = 1; t.expc = 32'hbfc00380;
        step("ex_d2", t);
        step("ex_d3", cy(1, 1, 0, '0, 0, '0));
        step("ex_d4", cy(1, 1, 1, 32'hbfc00380, 0, '0));
        step("ex_d5", cy(1, 1, 0, '0, 0, '0));
        step("ex_d6", cy(1, 1, 0, '0, 1, okb(32'hbfc00380)));
        step("ex_d7", cy(1, 1, 1, 32'hbfc00384, 0, '0));
        t = cy(1, 1, 0, '0, 0, '0); t.ex = 1; t.expc = 32'hbfc00400;
        step("ex_d8", t);
        step("ex_d9", cy(1, 1, 1, 32'hbfc00400, 0, '0));
        step("ex_d10", cy(1, 1, 0, '0, 0, '0));
        step("ex_d11", cy(1, 1, 0, '0, 1, okb(32'hbfc00400)));

        // exception to an unaligned address raises adel without a bus request
        do_reset();
        t = cy(0, 1, 0, '0, 0, '0); t.ex = 1; t.expc = 32'hbfc00382;
        step("adel_e0", t);
        step("adel_e1", cy(0, 1, 0, '0, 0, '0));
        step("adel_e2", cy(0, 1, 0, '0, 1, {1'b1, 32'hbfc00382, 32'h0}));
        step("adel_e3", cy(0, 1, 0, '0, 1, {1'b1, 32'hbfc00382, 32'h0}));
        step("adel_e4", cy(1, 1, 0, '0, 1, {1'b1, 32'hbfc00382, 32'h0}));
        step("adel_e5", cy(0, 1, 0, '0, 0, '0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Upstream neighbour of if_stage.
- Owns the fetch PC and drives the instruction-side SRAM-like bus (req / addr_ok / data_ok).
- Keeps at most one request in flight and buffers one returned instruction.
- Hands {adel, pc, inst} to if_stage with a valid/allowin handshake, and applies branch redirects (MIPS delay-slot semantics) and exception redirects, discarding wrong-path responses.

Parameters:
RESET_PC, 32'hbfc00000, first fetch address after reset
BR_BUS_WD, 65, width of br_bus = {br_taken[64], br_target[63:32], br_pc[31:0]}
PFS_TO_FS_BUS_WD, 65, width of output bus = {adel[64], pc[63:32], inst[31:0]}

Ports:
clk  in  1  clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
fs_allowin  in  1  if_stage can accept an instruction this cycle
br_bus  in  BR_BUS_WD  single-cycle taken-branch notice from decode
handle_ex  in  1  exception/eret flush pulse
ex_pc  in  32  redirect address accompanying handle_ex
pfs_to_fs_valid  out  1  output buffer holds a deliverable instruction
pfs_to_fs_bus  out  PFS_TO_FS_BUS_WD  {adel, pc, inst}
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10
inst_sram_addr  out  32  request address
inst_sram_wdata  out  32  constant 0
inst_sram_addr_ok  in  1  request accepted this cycle
inst_sram_data_ok  in  1  read data valid this cycle
inst_sram_rdata  in  32  read data

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC.
  - out_valid=0, out bus=0.
  - discard=0, br_pend=0.
  - inst_sram_req=0.
- States:
  - IDLE: req=0. Always moves to REQ next cycle.
  - REQ: req=1, addr=fetch_pc. addr/req are held stable until addr_ok. On addr_ok: go to WAIT, and set fetch_pc to the next address (see branch rules, default fetch_pc+4).
  - WAIT: req=0. On data_ok:
    - if discard=1: clear discard and go to REQ.
    - else: capture {0, issued_pc, rdata} into the output buffer, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1. When fs_allowin=1: out_valid<=0 and go to REQ (next request issues the following cycle).
- Data_ok is honoured only in WAIT; there is one outstanding request maximum. issued_pc is registered on addr_ok.
- Unaligned PC (fetch_pc[1:0]!=0 on entering REQ):
  - No bus request is issued.
  - Go straight to HOLD with {1, fetch_pc, 32'h0}.
  - fetch_pc is left unchanged until an exception redirect.
- Branch:
  - br_taken=1 latches br_pend=1, tgt=br_target, slot=br_pc+4.
  - The delay slot (address slot) must always be fetched sequentially.
  - Any request address equal to slot+4 is wrong-path and is replaced by tgt.
    - If fetch_pc==slot+4 and state is not REQ: fetch_pc<=tgt and clear br_pend in the same edge.
    - If state is REQ with addr==slot+4 (already asserted): the request completes, discard<=1 at addr_ok, fetch_pc<=tgt, clear br_pend.
    - If state is WAIT with issued_pc==slot+4: discard<=1, fetch_pc<=tgt, clear br_pend.
    - If the addr_ok address equals slot: next fetch_pc=tgt, clear br_pend.
  - If the output buffer holds slot+4 (HOLD, pc==slot+4): drop it (out_valid<=0), fetch_pc<=tgt, clear br_pend, go to REQ.
- Exception (handle_ex=1) has highest priority over branch and normal flow:
  - fetch_pc<=ex_pc, out_valid<=0, br_pend<=0.
  - From REQ (req stays stable until addr_ok) or WAIT: discard<=1 and continue until the response drains; the next request uses ex_pc.
  - From IDLE/HOLD: go to REQ.
  - A data_ok in the same cycle as handle_ex is discarded.
- A second handle_ex while discard=1 only updates fetch_pc; the discard count never exceeds 1.
- Output bus is held stable while out_valid=1 and fs_allowin=0.
- fetch_pc+4 wraps modulo 2^32.

Test Plan:
- Reset, then a memory with addr_ok=1 and data_ok one cycle later, fs_allowin=1 -> addresses bfc00000, bfc00004, bfc00008 issued in order; output bus pc/inst matches, one instruction per 3 cycles.
- fs_allowin=0 for 5 cycles while in HOLD with pc=bfc00004 -> bus stable, req=0 throughout; the next req (bfc00008) comes the cycle after fs_allowin rises.
- Branch br_pc=bfc00000, target=bfc00100, arriving while the slot bfc00004 is in WAIT -> next address bfc00100; bfc00008 is never requested.
- Branch arrives while req for slot+4=bfc00008 is held with addr_ok=0 for 3 cycles -> addr stays bfc00008; its data is discarded (no pfs_to_fs_valid); the next request is bfc00100.
- handle_ex with ex_pc=bfc00380 during WAIT -> the old response is dropped, out_valid stays 0, the next req addr is bfc00380.
- handle_ex with ex_pc=bfc00382 -> no req; pfs_to_fs_valid=1 with adel=1, pc=bfc00382, inst=0.
